// File: rtl/psg_edge_pkg.sv
// Shared types for the PSG edge detector bank.
// Mode encoding and bit positions used by every channel.
package psg_edge_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int MODE_W        = 2;
    localparam int MODE_RISE_BIT = 0;
    localparam int MODE_FALL_BIT = 1;

endpackage

// File: rtl/edge_channel.sv
// One edge detector channel: synchroniser, glitch filter,
// registered edge pulses and sticky event/overflow flags.
module edge_channel
    import psg_edge_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal_in,
    input  edge_mode_t mode,
    input  logic       clear,
    output logic       level,
    output logic       on_posedge,
    output logic       on_negedge,
    output logic       on_edge,
    output logic       event_pulse,
    output logic       event_flag,
    output logic       overflow
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          w_s;
    logic          w_flip;
    logic          w_event;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_pos;
    logic          r_neg;
    logic          r_flag;
    logic          r_ovf;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = signal_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= signal_in;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // A matching sample anywhere in the window restarts it.
    assign w_flip = (w_s != r_level) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_pos <= w_flip & w_s;
            r_neg <= w_flip & ~w_s;
            if ((w_s == r_level) || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_flip) begin
                r_level <= w_s;
            end
        end
    end

    assign w_event = (r_pos & mode[MODE_RISE_BIT])
                   | (r_neg & mode[MODE_FALL_BIT]);

    // A new event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_event) begin
                r_flag <= 1'b1;
            end else if (clear) begin
                r_flag <= 1'b0;
            end
            if (w_event && r_flag && !clear) begin
                r_ovf <= 1'b1;
            end else if (clear) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign level       = r_level;
    assign on_posedge  = r_pos;
    assign on_negedge  = r_neg;
    assign on_edge     = r_pos | r_neg;
    assign event_pulse = w_event;
    assign event_flag  = r_flag;
    assign overflow    = r_ovf;

endmodule

// File: rtl/edge_detector_bank.sv
// Bank of independent filtered edge detectors with
// per-channel event flags and a combined any_event.
module edge_detector_bank
    import psg_edge_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        signal_in,
    input  logic [MODE_W*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]        clear,
    output logic [CHANNELS-1:0]        level,
    output logic [CHANNELS-1:0]        on_posedge,
    output logic [CHANNELS-1:0]        on_negedge,
    output logic [CHANNELS-1:0]        on_edge,
    output logic [CHANNELS-1:0]        event_pulse,
    output logic [CHANNELS-1:0]        event_flag,
    output logic [CHANNELS-1:0]        overflow,
    output logic                       any_event
);

    generate
        if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_ch
            $fatal(1, "CHANNELS out of range 1..32");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
            $fatal(1, "SYNC_STAGES out of range 0..3");
        end
        if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_flt
            $fatal(1, "FILTER_CYCLES out of range 1..255");
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            edge_channel #(
                .SYNC_STAGES  (SYNC_STAGES),
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .signal_in  (signal_in[i]),
                .mode       (edge_mode_t'(mode[MODE_W*i +: MODE_W])),
                .clear      (clear[i]),
                .level      (level[i]),
                .on_posedge (on_posedge[i]),
                .on_negedge (on_negedge[i]),
                .on_edge    (on_edge[i]),
                .event_pulse(event_pulse[i]),
                .event_flag (event_flag[i]),
                .overflow   (overflow[i])
            );
        end
    endgenerate

    assign any_event = |event_flag;

endmodule
